// File: rtl/mult_div_pkg.sv
// mult_div_pkg: op encodings, FSM states and default width shared with the control FSM
package mult_div_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FINISH, S_DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on unsigned magnitudes
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   i_rem,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_rem,
  output logic         o_q
);
  assign o_q = i_rem >= {1'b0, i_div};
  assign o_rem = W'(o_q ? i_rem - {1'b0, i_div} : i_rem);
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (radix-2 Booth) / divide (restoring) producing HI/LO
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_m, r_hi, r_lo, w_amag, w_bmag, w_rem, w_q, w_r;
  logic [WIDTH:0] w_sum;
  logic r_op, r_dz, r_nq, r_nr, w_qbit, w_last, w_bz, w_iter;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_iter = r_state == S_MULT || r_state == S_DIV;
  assign w_bz = b == '0;
  assign w_amag = a[WIDTH-1] ? -a : a;
  assign w_bmag = b[WIDTH-1] ? -b : b;
  // Booth sum kept one bit wider so the arithmetic shift sees the true sign even for the most negative multiplicand
  assign w_sum = r_acc[1:0] == 2'b01 ? {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]} + {r_m[WIDTH-1], r_m}
               : r_acc[1:0] == 2'b10 ? {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]} - {r_m[WIDTH-1], r_m}
               : {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
  div_step #(.W(WIDTH)) u_div_step (
    .i_rem({r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]}),
    .i_div(r_m),
    .o_rem(w_rem),
    .o_q  (w_qbit)
  );
  assign w_q = r_nq ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r = r_nr ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign hi = r_hi;
  assign lo = r_lo;
  // Divide-by-zero passes through FINISH without loading hi/lo so done lands in the second cycle
  always_comb begin
    w_next = r_state;
    busy = r_state != S_IDLE;
    done = r_state == S_DONE;
    div_zero = r_state == S_DONE && r_dz;
    if (r_state == S_IDLE && start) w_next = op == OP_MULT ? S_MULT : w_bz ? S_FINISH : S_DIV;
    else if (w_iter && w_last) w_next = S_FINISH;
    else if (r_state == S_FINISH) w_next = S_DONE;
    else if (r_state == S_DONE) w_next = S_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_acc <= '0;
      r_m <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_op <= 1'b0;
      r_dz <= 1'b0;
      r_nq <= 1'b0;
      r_nr <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_iter ? r_cnt + 1'b1 : '0;
      if (r_state == S_IDLE && start) begin
        r_op <= op;
        r_dz <= op == OP_DIV && w_bz;
        r_nq <= a[WIDTH-1] ^ b[WIDTH-1];
        r_nr <= a[WIDTH-1];
        r_m <= op == OP_DIV ? w_bmag : a;
        r_acc <= op == OP_DIV ? {{(WIDTH+1){1'b0}}, w_amag} : {{WIDTH{1'b0}}, b, 1'b0};
      end
      if (r_state == S_MULT) r_acc <= {w_sum, r_acc[WIDTH:1]};
      if (r_state == S_DIV) r_acc <= {1'b0, w_rem, r_acc[WIDTH-2:0], w_qbit};
      if (r_state == S_FINISH && !r_dz) begin
        r_hi <= r_op == OP_DIV ? w_r : r_acc[2*WIDTH:WIDTH+1];
        r_lo <= r_op == OP_DIV ? w_q : r_acc[WIDTH:1];
      end
      if (r_state == S_DONE) r_dz <= 1'b0;
    end
  end
endmodule
